// File: rtl/serial_sub_ctrl_if.sv
// serial_sub_ctrl_if: operand/result handshake bundle for serial_sub_ctrl; ovf exists only under SERIAL_SUB_OVF_EN
interface serial_sub_ctrl_if #(parameter int WIDTH = 8);
  logic start, in_ready, out_valid, out_ready, bor, busy;
  logic [WIDTH-1:0] a, b, dif;
`ifdef SERIAL_SUB_OVF_EN
  logic ovf;
  modport master(output start, a, b, out_ready, input in_ready, out_valid, dif, bor, busy, ovf);
  modport slave(input start, a, b, out_ready, output in_ready, out_valid, dif, bor, busy, ovf);
`else
  modport master(output start, a, b, out_ready, input in_ready, out_valid, dif, bor, busy);
  modport slave(input start, a, b, out_ready, output in_ready, out_valid, dif, bor, busy);
`endif
endinterface

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial A-B, LSB first, one bit per clock with registered borrow; SERIAL_SUB_OVF_EN adds signed overflow
module serial_sub_ctrl #(parameter int WIDTH = 8) (
  input logic clk,
  input logic rst,
  serial_sub_ctrl_if.slave io
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, dif_sh_q, dif_sh_d, dif_q, dif_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic br_q, br_d, bor_q, bor_d;
  logic x, y, d, br_n;
  logic [WIDTH-1:0] dif_sh_n;
  assign x = a_sh_q[0];
  assign y = b_sh_q[0];
  assign d = x ^ y ^ br_q;
  assign br_n = (~x & y) | (~(x ^ y) & br_q);
  assign dif_sh_n = {d, dif_sh_q[WIDTH-1:1]};
`ifdef SERIAL_SUB_OVF_EN
  logic am_q, am_d, bm_q, bm_d, ovf_q, ovf_d;
  assign io.ovf = ovf_q;
`endif
  always_comb begin
    state_d = state_q;
    a_sh_d = a_sh_q;
    b_sh_d = b_sh_q;
    dif_sh_d = dif_sh_q;
    cnt_d = cnt_q;
    br_d = br_q;
    dif_d = dif_q;
    bor_d = bor_q;
`ifdef SERIAL_SUB_OVF_EN
    am_d = am_q;
    bm_d = bm_q;
    ovf_d = ovf_q;
`endif
    if (state_q == IDLE && io.start) begin
      a_sh_d = io.a;
      b_sh_d = io.b;
      br_d = 1'b0;
      cnt_d = '0;
      dif_sh_d = '0;
      state_d = RUN;
`ifdef SERIAL_SUB_OVF_EN
      am_d = io.a[WIDTH-1];
      bm_d = io.b[WIDTH-1];
`endif
    end else if (state_q == RUN) begin
      a_sh_d = a_sh_q >> 1;
      b_sh_d = b_sh_q >> 1;
      dif_sh_d = dif_sh_n;
      br_d = br_n;
      cnt_d = cnt_q + 1'b1;
      // the final bit lands straight in the held result registers
      if (cnt_q == CW'(WIDTH - 1)) begin
        state_d = DONE;
        dif_d = dif_sh_n;
        bor_d = br_n;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d = (am_q ^ bm_q) & (am_q ^ d);
`endif
      end
    end else if (state_q == DONE && io.out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q <= '0;
      b_sh_q <= '0;
      dif_sh_q <= '0;
      cnt_q <= '0;
      br_q <= 1'b0;
      dif_q <= '0;
      bor_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      am_q <= 1'b0;
      bm_q <= 1'b0;
      ovf_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q <= a_sh_d;
      b_sh_q <= b_sh_d;
      dif_sh_q <= dif_sh_d;
      cnt_q <= cnt_d;
      br_q <= br_d;
      dif_q <= dif_d;
      bor_q <= bor_d;
`ifdef SERIAL_SUB_OVF_EN
      am_q <= am_d;
      bm_q <= bm_d;
      ovf_q <= ovf_d;
`endif
    end
  end
  assign io.in_ready = state_q == IDLE;
  assign io.busy = state_q == RUN;
  assign io.out_valid = state_q == DONE;
  assign io.dif = dif_q;
  assign io.bor = bor_q;
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb_serial_sub_ctrl: directed checks of serial_sub_ctrl at WIDTH=8; ovf checks compiled in under SERIAL_SUB_OVF_EN
module tb_serial_sub_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  int checks = 0, failures = 0;
  serial_sub_ctrl_if #(.WIDTH(8)) io();
  serial_sub_ctrl #(.WIDTH(8)) dut(.clk(clk), .rst(rst), .io(io));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_sub(input logic [7:0] av, input logic [7:0] bv, output int lat, output int bc);
    io.a = av;
    io.b = bv;
    io.start = 1'b1;
    tick();
    io.start = 1'b0;
    lat = 0;
    bc = 0;
    while (!io.out_valid && lat < 50) begin
      bc += int'(io.busy);
      tick();
      lat++;
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (io.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", io.in_ready); end
    checks++; if (io.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", io.out_valid); end
    checks++; if (io.dif !== 8'h00) begin failures++; $display("FAIL reset_dif got=%h exp=00", io.dif); end
    checks++; if (io.bor !== 1'b0) begin failures++; $display("FAIL reset_bor got=%b exp=0", io.bor); end
    checks++; if (io.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", io.busy); end
  endtask
  task automatic test_basic;
    int lat, bc;
    io.out_ready = 1'b1;
    do_sub(8'h35, 8'h12, lat, bc);
    checks++; if (lat !== 8) begin failures++; $display("FAIL basic_latency got=%0d exp=8", lat); end
    checks++; if (bc !== 8) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=8", bc); end
    checks++; if (io.dif !== 8'h23) begin failures++; $display("FAIL basic_dif got=%h exp=23", io.dif); end
    checks++; if (io.bor !== 1'b0) begin failures++; $display("FAIL basic_bor got=%b exp=0", io.bor); end
    tick();
    checks++; if (io.in_ready !== 1'b1 || io.out_valid !== 1'b0) begin failures++; $display("FAIL basic_return_idle got=%b%b exp=10", io.in_ready, io.out_valid); end
  endtask
  task automatic test_vectors;
    logic [7:0] va [3] = '{8'h12, 8'h00, 8'hFF};
    logic [7:0] vb [3] = '{8'h35, 8'h01, 8'hFF};
    logic [7:0] vd [3] = '{8'hDD, 8'hFF, 8'h00};
    logic vbr [3] = '{1'b1, 1'b1, 1'b0};
    int lat, bc;
    io.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_sub(va[i], vb[i], lat, bc);
      checks++; if (lat !== 8) begin failures++; $display("FAIL vec%0d_latency got=%0d exp=8", i, lat); end
      checks++; if (io.dif !== vd[i]) begin failures++; $display("FAIL vec%0d_dif got=%h exp=%h", i, io.dif, vd[i]); end
      checks++; if (io.bor !== vbr[i]) begin failures++; $display("FAIL vec%0d_bor got=%b exp=%b", i, io.bor, vbr[i]); end
      tick();
    end
  endtask
  task automatic test_backpressure;
    int lat, bc;
    io.out_ready = 1'b0;
    do_sub(8'hA5, 8'h5A, lat, bc);
    checks++; if (lat !== 8) begin failures++; $display("FAIL bp_latency got=%0d exp=8", lat); end
    for (int i = 0; i < 5; i++) begin
      io.start = (i == 2);
      io.a = 8'h01;
      io.b = 8'h02;
      tick();
      checks++; if (io.out_valid !== 1'b1 || io.in_ready !== 1'b0 || io.busy !== 1'b0) begin failures++; $display("FAIL bp_hold_flags%0d got=%b%b%b exp=100", i, io.out_valid, io.in_ready, io.busy); end
      checks++; if (io.dif !== 8'h4B || io.bor !== 1'b0) begin failures++; $display("FAIL bp_hold_result%0d got=%h/%b exp=4b/0", i, io.dif, io.bor); end
    end
    io.start = 1'b0;
    io.out_ready = 1'b1;
    tick();
    checks++; if (io.in_ready !== 1'b1 || io.out_valid !== 1'b0) begin failures++; $display("FAIL bp_release got=%b%b exp=10", io.in_ready, io.out_valid); end
    checks++; if (io.dif !== 8'h4B) begin failures++; $display("FAIL bp_dif_kept got=%h exp=4b", io.dif); end
  endtask
  task automatic test_back_to_back;
    int lat, bc;
    io.out_ready = 1'b1;
    do_sub(8'h50, 8'h20, lat, bc);
    checks++; if (io.dif !== 8'h30) begin failures++; $display("FAIL b2b_first_dif got=%h exp=30", io.dif); end
    io.a = 8'h40;
    io.b = 8'h01;
    io.start = 1'b1;
    tick();
    checks++; if (io.in_ready !== 1'b1 || io.busy !== 1'b0) begin failures++; $display("FAIL b2b_not_accepted got=%b%b exp=10", io.in_ready, io.busy); end
    tick();
    io.start = 1'b0;
    checks++; if (io.busy !== 1'b1) begin failures++; $display("FAIL b2b_accepted got=%b exp=1", io.busy); end
    io.a = 8'h00;
    io.b = 8'hFF;
    lat = 0;
    while (!io.out_valid && lat < 50) begin tick(); lat++; end
    checks++; if (lat !== 8) begin failures++; $display("FAIL b2b_latency got=%0d exp=8", lat); end
    checks++; if (io.dif !== 8'h3F || io.bor !== 1'b0) begin failures++; $display("FAIL b2b_no_resample got=%h/%b exp=3f/0", io.dif, io.bor); end
    tick();
  endtask
  task automatic test_reset_mid_run;
    int lat, bc;
    io.out_ready = 1'b1;
    io.a = 8'h35;
    io.b = 8'h12;
    io.start = 1'b1;
    tick();
    io.start = 1'b0;
    repeat (4) tick();
    checks++; if (io.busy !== 1'b1) begin failures++; $display("FAIL rst_mid_busy_before got=%b exp=1", io.busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (io.busy !== 1'b0 || io.out_valid !== 1'b0 || io.in_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_state got=%b%b%b exp=001", io.busy, io.out_valid, io.in_ready); end
    checks++; if (io.dif !== 8'h00 || io.bor !== 1'b0) begin failures++; $display("FAIL rst_mid_result got=%h/%b exp=00/0", io.dif, io.bor); end
    do_sub(8'h10, 8'h01, lat, bc);
    checks++; if (lat !== 8) begin failures++; $display("FAIL rst_mid_fresh_latency got=%0d exp=8", lat); end
    checks++; if (io.dif !== 8'h0F || io.bor !== 1'b0) begin failures++; $display("FAIL rst_mid_fresh got=%h/%b exp=0f/0", io.dif, io.bor); end
    tick();
  endtask
`ifdef SERIAL_SUB_OVF_EN
  task automatic test_ovf;
    logic [7:0] va [3] = '{8'h80, 8'h7F, 8'h05};
    logic [7:0] vb [3] = '{8'h01, 8'hFF, 8'h03};
    logic [7:0] vd [3] = '{8'h7F, 8'h80, 8'h02};
    logic vbr [3] = '{1'b0, 1'b1, 1'b0};
    logic vo [3] = '{1'b1, 1'b1, 1'b0};
    int lat, bc;
    io.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_sub(va[i], vb[i], lat, bc);
      checks++; if (io.dif !== vd[i] || io.bor !== vbr[i]) begin failures++; $display("FAIL ovf%0d_result got=%h/%b exp=%h/%b", i, io.dif, io.bor, vd[i], vbr[i]); end
      checks++; if (io.ovf !== vo[i]) begin failures++; $display("FAIL ovf%0d_flag got=%b exp=%b", i, io.ovf, vo[i]); end
      tick();
    end
  endtask
`endif
  initial begin
    io.start = 1'b0;
    io.a = '0;
    io.b = '0;
    io.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_vectors();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
`ifdef SERIAL_SUB_OVF_EN
    test_ovf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
